// File: rtl/arb_requester_if.sv
// Requester-side bundle: job intake, arbiter request/grant, and the shared burst bus.
interface arb_requester_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
);
   logic              job_valid;
   logic              job_ready;
   logic [LEN_W-1:0]  job_len;
   logic [DATA_W-1:0] job_base;
   logic              req;
   logic              gnt;
   logic              bus_valid;
   logic              bus_ready;
   logic [DATA_W-1:0] bus_data;
   logic              bus_last;
   logic              err;

   modport master (
      input  job_valid, job_len, job_base, gnt, bus_ready,
      output job_ready, req, bus_valid, bus_data, bus_last, err
   );

   modport slave (
      output job_valid, job_len, job_base, gnt, bus_ready,
      input  job_ready, req, bus_valid, bus_data, bus_last, err
   );
endinterface

// File: rtl/arb_requester.sv
// Arbiter client: takes one burst job, requests, streams len+1 beats on grant, then releases; all outputs registered.
// Job->req 1 cycle, gnt->beat 1 cycle, last beat->req low 1 cycle; bus_ready=0 holds the beat. Grant timeout under ARB_REQ_TIMEOUT_EN.
module arb_requester #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4,
   parameter int TMO_W  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   arb_requester_if.master ifc
);
   typedef enum logic [1:0] {IDLE, WAIT, XFER, REL} state_t;

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] base_q;
   logic              req_q;
   logic              job_ready_q;
   logic              bus_valid_q;
   logic              bus_last_q;
   logic [DATA_W-1:0] bus_data_q;

`ifdef ARB_REQ_TIMEOUT_EN
   logic [TMO_W-1:0]  tmo;
   logic [TMO_W-1:0]  tmo_inc;
   logic              err_q;

   assign tmo_inc = tmo + 1'b1;
`endif

   assign cnt_inc = cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         len_q       <= '0;
         base_q      <= '0;
         cnt         <= '0;
         req_q       <= 1'b0;
         job_ready_q <= 1'b0;
         bus_valid_q <= 1'b0;
         bus_last_q  <= 1'b0;
         bus_data_q  <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
         tmo         <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
`ifdef ARB_REQ_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // job_ready is registered, so the first cycle out of reset only arms it
               if (job_ready_q && ifc.job_valid) begin
                  len_q       <= ifc.job_len;
                  base_q      <= ifc.job_base;
                  cnt         <= '0;
                  req_q       <= 1'b1;
                  job_ready_q <= 1'b0;
                  state       <= WAIT;
               end else begin
                  job_ready_q <= 1'b1;
               end
            end

            WAIT: begin
`ifdef ARB_REQ_TIMEOUT_EN
               if (tmo == '1) begin
                  // err already pulsed when the counter reached all-ones; drop the job
                  tmo   <= '0;
                  req_q <= 1'b0;
                  state <= REL;
               end else if (ifc.gnt) begin
                  tmo         <= '0;
                  bus_valid_q <= 1'b1;
                  bus_data_q  <= base_q + DATA_W'(cnt);
                  bus_last_q  <= (cnt == len_q);
                  state       <= XFER;
               end else begin
                  tmo <= tmo_inc;
                  if (tmo_inc == '1) begin
                     err_q <= 1'b1;
                  end
               end
`else
               if (ifc.gnt) begin
                  bus_valid_q <= 1'b1;
                  bus_data_q  <= base_q + DATA_W'(cnt);
                  bus_last_q  <= (cnt == len_q);
                  state       <= XFER;
               end
`endif
            end

            XFER: begin
               if (ifc.bus_ready) begin
                  cnt <= cnt_inc;
                  if (bus_last_q) begin
                     req_q       <= 1'b0;
                     bus_valid_q <= 1'b0;
                     bus_last_q  <= 1'b0;
                     state       <= REL;
                  end else if (ifc.gnt) begin
                     bus_data_q <= base_q + DATA_W'(cnt_inc);
                     bus_last_q <= (cnt_inc == len_q);
                  end else begin
                     bus_valid_q <= 1'b0;
                     bus_last_q  <= 1'b0;
                     state       <= WAIT;
                  end
               end else if (!ifc.gnt) begin
                  // grant lost with the beat still pending: park and resume this beat later
                  bus_valid_q <= 1'b0;
                  bus_last_q  <= 1'b0;
                  state       <= WAIT;
               end
            end

            REL: begin
               job_ready_q <= 1'b1;
               state       <= IDLE;
            end

            default: begin
               req_q       <= 1'b0;
               bus_valid_q <= 1'b0;
               bus_last_q  <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign ifc.req       = req_q;
   assign ifc.job_ready = job_ready_q;
   assign ifc.bus_valid = bus_valid_q;
   assign ifc.bus_data  = bus_data_q;
   assign ifc.bus_last  = bus_last_q;

`ifdef ARB_REQ_TIMEOUT_EN
   assign ifc.err = err_q;
`else
   // no timeout hardware in this build: err is a constant low
   assign ifc.err = |{TMO_W{1'b0}};
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: reset, basic burst, backpressure, wrap, grant loss, mid-burst reset, grant timeout.
module tb_arb_requester;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;
   localparam int TMO_W  = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   arb_requester_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus_if ();

   arb_requester #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ifc   (bus_if.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [7:0] data, input logic last);
      chk({tag, "_valid"}, 32'(bus_if.bus_valid), 32'd1);
      chk({tag, "_data"},  32'(bus_if.bus_data),  32'(data));
      chk({tag, "_last"},  32'(bus_if.bus_last),  32'(last));
      chk({tag, "_req"},   32'(bus_if.req),       32'd1);
   endtask

   task automatic offer(input logic [3:0] len, input logic [7:0] base);
      bus_if.job_valid = 1'b1;
      bus_if.job_len   = len;
      bus_if.job_base  = base;
      tick();
      bus_if.job_valid = 1'b0;
      chk("accept_req",       32'(bus_if.req),       32'd1);
      chk("accept_job_ready", 32'(bus_if.job_ready), 32'd0);
      chk("accept_bus_valid", 32'(bus_if.bus_valid), 32'd0);
   endtask

   task automatic release_seq(input string tag);
      tick();
      chk({tag, "_rel_req"},       32'(bus_if.req),       32'd0);
      chk({tag, "_rel_bus_valid"}, 32'(bus_if.bus_valid), 32'd0);
      chk({tag, "_rel_job_ready"}, 32'(bus_if.job_ready), 32'd0);
      bus_if.gnt       = 1'b0;
      bus_if.bus_ready = 1'b0;
      tick();
      chk({tag, "_idle_job_ready"}, 32'(bus_if.job_ready), 32'd1);
      chk({tag, "_idle_req"},       32'(bus_if.req),       32'd0);
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      rst_n            = 1'b0;
      bus_if.job_valid = 1'b0;
      bus_if.job_len   = '0;
      bus_if.job_base  = '0;
      bus_if.gnt       = 1'b0;
      bus_if.bus_ready = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_req",       32'(bus_if.req),       32'd0);
      chk("rst_bus_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("rst_bus_last",  32'(bus_if.bus_last),  32'd0);
      chk("rst_bus_data",  32'(bus_if.bus_data),  32'd0);
      chk("rst_err",       32'(bus_if.err),       32'd0);
      chk("rst_job_ready", 32'(bus_if.job_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_job_ready", 32'(bus_if.job_ready), 32'd1);

      // basic: len 3, base 10, grant 2 cycles after req; a second job offered in WAIT is ignored
      bus_if.job_valid = 1'b1;
      bus_if.job_len   = 4'd3;
      bus_if.job_base  = 8'h10;
      tick();
      chk("basic_req",       32'(bus_if.req),       32'd1);
      chk("basic_job_ready", 32'(bus_if.job_ready), 32'd0);
      bus_if.job_len  = 4'd9;
      bus_if.job_base = 8'h99;
      tick();
      bus_if.job_valid = 1'b0;
      chk("basic_wait_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("basic_wait_req",   32'(bus_if.req),       32'd1);
      bus_if.gnt       = 1'b1;
      bus_if.bus_ready = 1'b1;
      tick(); chk_beat("basic_b0", 8'h10, 1'b0);
      tick(); chk_beat("basic_b1", 8'h11, 1'b0);
      tick(); chk_beat("basic_b2", 8'h12, 1'b0);
      tick(); chk_beat("basic_b3", 8'h13, 1'b1);
      release_seq("basic");

      // backpressure: beat 0 held for 3 cycles
      offer(4'd1, 8'h20);
      bus_if.gnt = 1'b1;
      tick(); chk_beat("bp_hold0", 8'h20, 1'b0);
      tick(); chk_beat("bp_hold1", 8'h20, 1'b0);
      tick(); chk_beat("bp_hold2", 8'h20, 1'b0);
      bus_if.bus_ready = 1'b1;
      tick(); chk_beat("bp_b1", 8'h21, 1'b1);
      release_seq("bp");

      // data wraps modulo 256
      offer(4'd2, 8'hFE);
      bus_if.gnt       = 1'b1;
      bus_if.bus_ready = 1'b1;
      tick(); chk_beat("wrap_b0", 8'hFE, 1'b0);
      tick(); chk_beat("wrap_b1", 8'hFF, 1'b0);
      tick(); chk_beat("wrap_b2", 8'h00, 1'b1);
      release_seq("wrap");

      // grant loss after beat 1 accepted; resume at beat 2
      offer(4'd4, 8'h40);
      bus_if.gnt       = 1'b1;
      bus_if.bus_ready = 1'b1;
      tick(); chk_beat("gl_b0", 8'h40, 1'b0);
      tick(); chk_beat("gl_b1", 8'h41, 1'b0);
      tick(); chk_beat("gl_b2_pre", 8'h42, 1'b0);
      bus_if.gnt       = 1'b0;
      bus_if.bus_ready = 1'b0;
      tick();
      chk("gl_drop_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("gl_drop_req",   32'(bus_if.req),       32'd1);
      tick();
      chk("gl_wait_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("gl_wait_req",   32'(bus_if.req),       32'd1);
      bus_if.gnt       = 1'b1;
      bus_if.bus_ready = 1'b1;
      tick(); chk_beat("gl_b2", 8'h42, 1'b0);
      tick(); chk_beat("gl_b3", 8'h43, 1'b0);
      tick(); chk_beat("gl_b4", 8'h44, 1'b1);
      release_seq("gl");

      // reset held 2 cycles mid-burst aborts it
      offer(4'd7, 8'h80);
      bus_if.gnt       = 1'b1;
      bus_if.bus_ready = 1'b1;
      tick(); chk_beat("mr_b0", 8'h80, 1'b0);
      tick(); chk_beat("mr_b1", 8'h81, 1'b0);
      rst_n = 1'b0;
      tick();
      chk("mr_req",       32'(bus_if.req),       32'd0);
      chk("mr_bus_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("mr_bus_data",  32'(bus_if.bus_data),  32'd0);
      tick();
      chk("mr_job_ready", 32'(bus_if.job_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("mr_post_job_ready", 32'(bus_if.job_ready), 32'd1);
      chk("mr_post_req",       32'(bus_if.req),       32'd0);
      chk("mr_post_valid",     32'(bus_if.bus_valid), 32'd0);
      bus_if.gnt       = 1'b0;
      bus_if.bus_ready = 1'b0;

      // grant never arrives
      offer(4'd0, 8'h05);
`ifdef ARB_REQ_TIMEOUT_EN
      for (int i = 1; i < 15; i++) begin
         tick();
         chk("tmo_wait_err", 32'(bus_if.err), 32'd0);
         chk("tmo_wait_req", 32'(bus_if.req), 32'd1);
      end
      tick();
      chk("tmo_err_pulse", 32'(bus_if.err), 32'd1);
      chk("tmo_err_req",   32'(bus_if.req), 32'd1);
      tick();
      chk("tmo_err_clear", 32'(bus_if.err),       32'd0);
      chk("tmo_req_low",   32'(bus_if.req),       32'd0);
      chk("tmo_rel_ready", 32'(bus_if.job_ready), 32'd0);
      tick();
      chk("tmo_job_ready", 32'(bus_if.job_ready), 32'd1);
`else
      for (int i = 1; i < 20; i++) begin
         tick();
         chk("notmo_err",   32'(bus_if.err),       32'd0);
         chk("notmo_req",   32'(bus_if.req),       32'd1);
         chk("notmo_valid", 32'(bus_if.bus_valid), 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
